// File: rtl/nrdiv_arb_seq.sv
// nrdiv_arb_seq: iterative non-restoring unsigned divider
// shared by two requesters through a round-robin arbiter.
module nrdiv_arb_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [N-1:0] dividend0,
  input  logic [N-1:0] divisor0,
  output logic         gnt0,
  input  logic         req1,
  input  logic [N-1:0] dividend1,
  input  logic [N-1:0] divisor1,
  output logic         gnt1,
  output logic         busy,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         dbz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] CORR = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CW = $clog2(N + 1);

  logic [1:0]    state;
  logic          last;
  logic          id_q;
  logic [CW-1:0] cnt;
  logic [N:0]    a;
  logic [N:0]    m;
  logic [N-1:0]  q;

  logic          any_req;
  logic          win;
  logic          gnt_ok;
  logic [N-1:0]  sel_dd;
  logic [N-1:0]  sel_dv;

  logic [N:0]    a_sh;
  logic [N:0]    a_it;
  logic [N-1:0]  q_it;
  logic [N:0]    a_corr;

  // Round-robin pick; the grant is withheld while in reset
  always_comb begin
    any_req = req0 | req1;
    win     = (req0 && req1) ? ~last : req1;
    gnt_ok  = rst_n && (state == IDLE) && any_req;
    gnt0    = gnt_ok && !win;
    gnt1    = gnt_ok && win;
    sel_dd  = win ? dividend1 : dividend0;
    sel_dv  = win ? divisor1 : divisor0;
  end

  // One non-restoring step and the final remainder fix-up
  always_comb begin
    a_sh   = {a[N-1:0], q[N-1]};
    a_it   = a[N] ? (a_sh + m) : (a_sh - m);
    q_it   = {q[N-2:0], ~a_it[N]};
    a_corr = a[N] ? (a + m) : a;
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy      = (state != IDLE);
    rsp_valid = rst_n && (state == DONE);
  end

  // Sequencer, datapath registers and held response fields
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      id_q   <= 1'b0;
      cnt    <= '0;
      a      <= '0;
      m      <= '0;
      q      <= '0;
      rsp_id <= 1'b0;
      quot   <= '0;
      rem    <= '0;
      dbz    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            last <= win;
            id_q <= win;
            m    <= {1'b0, sel_dv};
            if (sel_dv == '0) begin
              quot   <= '1;
              rem    <= sel_dd;
              dbz    <= 1'b1;
              rsp_id <= win;
              state  <= DONE;
            end else begin
              a     <= '0;
              q     <= sel_dd;
              cnt   <= CW'(N);
              state <= ITER;
            end
          end
        end
        ITER: begin
          a   <= a_it;
          q   <= q_it;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= CORR;
          end
        end
        CORR: begin
          a      <= a_corr;
          quot   <= q;
          rem    <= a_corr[N-1:0];
          dbz    <= 1'b0;
          rsp_id <= id_q;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nrdiv_arb_seq.sv
// tb_nrdiv_arb_seq: directed table plus corner sequences
// and a full operand sweep for nrdiv_arb_seq (N=4).
module tb_nrdiv_arb_seq;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         req0;
  logic [N-1:0] dividend0;
  logic [N-1:0] divisor0;
  logic         gnt0;
  logic         req1;
  logic [N-1:0] dividend1;
  logic [N-1:0] divisor1;
  logic         gnt1;
  logic         busy;
  logic         rsp_valid;
  logic         rsp_id;
  logic [N-1:0] quot;
  logic [N-1:0] rem;
  logic         dbz;

  int checks;
  int errors;

  typedef struct {
    bit       id;
    bit [3:0] dd;
    bit [3:0] dv;
    bit [3:0] q;
    bit [3:0] r;
    bit       z;
  } vec_t;

  vec_t tbl[10];

  nrdiv_arb_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .dividend0 (dividend0),
    .divisor0  (divisor0),
    .gnt0      (gnt0),
    .req1      (req1),
    .dividend1 (dividend1),
    .divisor1  (divisor1),
    .gnt1      (gnt1),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .quot      (quot),
    .rem       (rem),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // called at the negedge of cycle t+1 after a grant in cycle t
  task automatic collect(input int exp_lat, input bit id,
                         input int eq, input int er, input bit ez);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_valid", int'(rsp_valid), 1);
    chk("latency", lat, exp_lat);
    chk("rsp_id", int'(rsp_id), int'(id));
    chk("quot", int'(quot), eq);
    chk("rem", int'(rem), er);
    chk("dbz", int'(dbz), int'(ez));
  endtask

  task automatic run_op(input bit id, input bit [3:0] dd,
                        input bit [3:0] dv, input int eq,
                        input int er, input bit ez);
    int n;
    @(negedge clk);
    if (id) begin
      req1 = 1'b1; dividend1 = dd; divisor1 = dv;
      dividend0 = 4'hA; divisor0 = 4'h0;
    end else begin
      req0 = 1'b1; dividend0 = dd; divisor0 = dv;
      dividend1 = 4'h5; divisor1 = 4'h0;
    end
    #1;
    n = 0;
    while (!(id ? gnt1 : gnt0) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("gnt", int'(id ? gnt1 : gnt0), 1);
    chk("other_gnt", int'(id ? gnt0 : gnt1), 0);
    chk("busy_at_grant", int'(busy), 0);
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    chk("busy_after_grant", int'(busy), 1);
    collect((dv == 0) ? 1 : N + 2, id, eq, er, ez);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    req0 = 1'b0; dividend0 = '0; divisor0 = '0;
    req1 = 1'b0; dividend1 = '0; divisor1 = '0;

    tbl[0] = '{0, 13, 3, 4, 1, 0};
    tbl[1] = '{1, 3, 9, 0, 3, 0};
    tbl[2] = '{0, 7, 0, 15, 7, 1};
    tbl[3] = '{1, 0, 5, 0, 0, 0};
    tbl[4] = '{0, 15, 15, 1, 0, 0};
    tbl[5] = '{1, 9, 2, 4, 1, 0};
    tbl[6] = '{1, 5, 0, 15, 5, 1};
    tbl[7] = '{0, 8, 8, 1, 0, 0};
    tbl[8] = '{0, 15, 2, 7, 1, 0};
    tbl[9] = '{1, 14, 4, 3, 2, 0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_quot", int'(quot), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_dbz", int'(dbz), 0);
    chk("rst_gnt0", int'(gnt0), 0);

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].id, tbl[i].dd, tbl[i].dv,
             int'(tbl[i].q), int'(tbl[i].r), tbl[i].z);
    end

    // both requesters held from reset: alternation 0,1,0
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b1; dividend0 = 4'd15; divisor0 = 4'd1;
    req1 = 1'b1; dividend1 = 4'd15; divisor1 = 4'd15;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("tie1_gnt0", int'(gnt0), 1);
    chk("tie1_gnt1", int'(gnt1), 0);
    repeat (N + 2) @(negedge clk);
    chk("tie1_valid", int'(rsp_valid), 1);
    chk("tie1_id", int'(rsp_id), 0);
    chk("tie1_quot", int'(quot), 15);
    chk("tie1_rem", int'(rem), 0);
    @(negedge clk);
    #1;
    chk("tie2_gnt1", int'(gnt1), 1);
    chk("tie2_gnt0", int'(gnt0), 0);
    repeat (N + 2) @(negedge clk);
    chk("tie2_valid", int'(rsp_valid), 1);
    chk("tie2_id", int'(rsp_id), 1);
    chk("tie2_quot", int'(quot), 1);
    chk("tie2_rem", int'(rem), 0);
    @(negedge clk);
    #1;
    chk("tie3_gnt0", int'(gnt0), 1);
    chk("tie3_gnt1", int'(gnt1), 0);
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    collect(N + 2, 0, 15, 0, 0);

    // leave non-zero held fields before the abort test
    run_op(1, 14, 4, 3, 2, 0);

    // reset during the second ITER cycle of 12/5
    @(negedge clk);
    req0 = 1'b1; dividend0 = 4'd12; divisor0 = 4'd5;
    #1;
    chk("abort_gnt0", int'(gnt0), 1);
    @(negedge clk);
    dividend0 = 4'd1; divisor0 = 4'd1;
    chk("abort_iter1_valid", int'(rsp_valid), 0);
    @(negedge clk);
    chk("abort_iter2_busy", int'(busy), 1);
    rst_n = 1'b0;
    dividend0 = 4'd12; divisor0 = 4'd5;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(rsp_valid), 0);
    chk("abort_id", int'(rsp_id), 0);
    chk("abort_quot", int'(quot), 0);
    chk("abort_rem", int'(rem), 0);
    chk("abort_dbz", int'(dbz), 0);
    chk("abort_gnt_in_rst", int'(gnt0), 0);
    rst_n = 1'b1;
    #1;
    chk("abort_regrant", int'(gnt0), 1);
    @(negedge clk);
    req0 = 1'b0;
    collect(N + 2, 0, 2, 2, 0);

    // full sweep with alternating requesters
    for (int dd = 0; dd < 16; dd++) begin
      for (int dv = 1; dv < 16; dv++) begin
        run_op(bit'((dd + dv) & 1), 4'(dd), 4'(dv),
               dd / dv, dd % dv, 1'b0);
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
